// File: rtl/dram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_ctrl_pkg
// Description : Shared widths and FSM state encoding for the DRAM sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_ctrl_pkg;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 8;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_IDLE = 3'd0;
    localparam state_t c_ROW  = 3'd1;
    localparam state_t c_ACT  = 3'd2;
    localparam state_t c_COL  = 3'd3;
    localparam state_t c_PRE  = 3'd4;
    localparam state_t c_RCSR = 3'd5;
    localparam state_t c_RREF = 3'd6;

endpackage
`default_nettype wire

// File: rtl/dram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module      : dram_refresh_timer
// Description : Free-running refresh interval timer with pending/overrun flags.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_refresh_timer #(
    parameter int REF_INTERVAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic ref_taken,
    output logic ref_pend,
    output logic ref_overrun
);

    localparam int c_TW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [c_TW-1:0] r_timer;
    logic            r_pend;
    logic            r_overrun;
    logic            w_wrap;

    assign w_wrap = (r_timer == c_TW'(REF_INTERVAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_pend    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timer <= w_wrap ? '0 : r_timer + 1'b1;
            // A wrap coinciding with a take re-arms the flag for the next refresh.
            if (w_wrap)
                r_pend <= 1'b1;
            else if (ref_taken)
                r_pend <= 1'b0;
            if (w_wrap && r_pend && !ref_taken)
                r_overrun <= 1'b1;
        end
    end

    assign ref_pend    = r_pend;
    assign ref_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dram_ctrl
// Description : RAS/CAS sequencer for a 256K x 16 async DRAM with CBR refresh.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int T_RCD        = 2,
    parameter int T_CAS        = 2,
    parameter int T_RAS        = 5,
    parameter int T_RP         = 3,
    parameter int T_CHR        = 2,
    parameter int REF_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              ref_overrun,
    output logic [ROW_W-1:0]  ma,
    output logic              ras_n,
    output logic              cas_n,
    output logic              uwe_n,
    output logic              lwe_n,
    output logic              oe_n,
    output logic [DATA_W-1:0] dq_out,
    output logic              dq_oe,
    input  logic [DATA_W-1:0] dq_in
);

    localparam int COL_LEN = (T_CAS > T_RAS - T_RCD) ? T_CAS : T_RAS - T_RCD;
    localparam int c_M1    = (T_RCD > COL_LEN) ? T_RCD : COL_LEN;
    localparam int c_M2    = (T_RP > T_RAS) ? T_RP : T_RAS;
    localparam int c_MAXD  = (c_M1 > c_M2) ? c_M1 : c_M2;
    localparam int c_CW    = $clog2(c_MAXD + 1);

    state_t              r_state;
    logic [c_CW-1:0]     r_cnt;
    logic                r_we;
    logic [1:0]          r_be;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_acc;
    logic                w_ref_pend;
    logic                w_decide;
    logic                w_take_ref;
    logic                w_accept;
    logic [ROW_W-1:0]    w_row;
    logic [COL_W-1:0]    w_col;

    dram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .clk         (clk),
        .rst         (rst),
        .ref_taken   (w_take_ref),
        .ref_pend    (w_ref_pend),
        .ref_overrun (ref_overrun)
    );

    // The last precharge cycle makes the same decision as IDLE, so
    // back-to-back accesses need no idle gap.
    assign w_decide   = (r_state == c_IDLE) || ((r_state == c_PRE) && (r_cnt == '0));
    assign w_take_ref = w_decide && w_ref_pend;
    assign w_accept   = w_decide && !w_ref_pend && req;
    assign w_row      = r_addr[ADDR_W-1:COL_W];
    assign w_col      = r_addr[COL_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_be    <= 2'b00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_acc   <= 1'b0;
        end else if (w_take_ref) begin
            r_state <= c_RCSR;
            r_cnt   <= '0;
            r_acc   <= 1'b0;
        end else if (w_accept) begin
            r_state <= c_ROW;
            r_cnt   <= '0;
            r_we    <= we;
            r_be    <= be;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_acc   <= 1'b1;
        end else if (w_decide) begin
            r_state <= c_IDLE;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end else begin
            case (r_state)
                c_ROW: begin
                    r_state <= c_ACT;
                    r_cnt   <= c_CW'(T_RCD - 1);
                end
                c_ACT: begin
                    r_state <= c_COL;
                    r_cnt   <= c_CW'(COL_LEN - 1);
                end
                c_COL: begin
                    r_state <= c_PRE;
                    r_cnt   <= c_CW'(T_RP - 1);
                    if (!r_we)
                        r_rdata <= dq_in;
                end
                c_RCSR: begin
                    r_state <= c_RREF;
                    r_cnt   <= c_CW'(T_RAS - 1);
                end
                c_RREF: begin
                    r_state <= c_PRE;
                    r_cnt   <= c_CW'(T_RP - 1);
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        ras_n  = 1'b1;
        cas_n  = 1'b1;
        uwe_n  = 1'b1;
        lwe_n  = 1'b1;
        oe_n   = 1'b1;
        ma     = '0;
        ack    = 1'b0;
        case (r_state)
            c_ROW: ma = w_row;
            c_ACT: begin
                ras_n = 1'b0;
                ma    = (r_cnt == c_CW'(T_RCD - 1)) ? w_row : {2'b00, w_col};
            end
            c_COL: begin
                ras_n = 1'b0;
                cas_n = 1'b0;
                ma    = {2'b00, w_col};
                if (r_we) begin
                    uwe_n = ~r_be[1];
                    lwe_n = ~r_be[0];
                end else begin
                    oe_n = 1'b0;
                end
            end
            c_PRE:  ack = r_acc && (r_cnt == c_CW'(T_RP - 1));
            c_RCSR: cas_n = 1'b0;
            c_RREF: begin
                ras_n = 1'b0;
                cas_n = (r_cnt < c_CW'(T_RAS - T_CHR));
            end
            default: ;
        endcase
        dq_oe  = r_we && ((r_state == c_ACT) || (r_state == c_COL));
        dq_out = dq_oe ? r_wdata : '0;
    end

    assign busy  = (r_state != c_IDLE);
    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_ctrl
// Description : Self-checking bench for dram_ctrl with a behavioural DRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_ctrl;

    localparam int T_RCD   = 2;
    localparam int T_RAS   = 5;
    localparam int T_RP    = 3;
    localparam int COL_LEN = 3;
    localparam int REF_INT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [17:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        ack, busy, ref_overrun, ras_n, cas_n, uwe_n, lwe_n, oe_n, dq_oe;
    logic [15:0] rdata, dq_out, dq_in;
    logic [9:0]  ma;

    logic        ack2, busy2, ov2, ras2, cas2, uwe2, lwe2, oe2, dqoe2;
    logic [15:0] rdata2, dqo2;
    logic [9:0]  ma2;

    dram_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .ref_overrun(ref_overrun), .ma(ma),
        .ras_n(ras_n), .cas_n(cas_n), .uwe_n(uwe_n), .lwe_n(lwe_n), .oe_n(oe_n),
        .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
    );

    dram_ctrl #(.T_RP(60)) dut2 (
        .clk(clk), .rst(rst2), .req(1'b0), .we(1'b0), .be(2'b00), .addr(18'h0), .wdata(16'h0),
        .ack(ack2), .rdata(rdata2), .busy(busy2), .ref_overrun(ov2), .ma(ma2),
        .ras_n(ras2), .cas_n(cas2), .uwe_n(uwe2), .lwe_n(lwe2), .oe_n(oe2),
        .dq_out(dqo2), .dq_oe(dqoe2), .dq_in(16'h0)
    );

    // Behavioural DRAM: row latched on RAS fall, data through the dq_oe bus mux.
    logic [15:0] dmem [0:262143];
    logic [9:0]  dram_row;
    logic        prev_ras;

    always_comb begin
        if (!oe_n && !cas_n)
            dq_in = dmem[{dram_row, ma[7:0]}];
        else if (dq_oe)
            dq_in = dq_out;
        else
            dq_in = 16'h0;
    end

    always @(posedge clk) begin
        prev_ras <= ras_n;
        if (!ras_n && prev_ras === 1'b1)
            dram_row <= ma;
        if (!ras_n && !cas_n && dq_oe) begin
            if (!uwe_n) dmem[{dram_row, ma[7:0]}][15:8] <= dq_out[15:8];
            if (!lwe_n) dmem[{dram_row, ma[7:0]}][7:0]  <= dq_out[7:0];
        end
    end

    // Pin monitor: strobe run lengths, byte lanes seen in COL, CBR ordering, acks.
    int   cyc, ras_run, cas_run, ras_last, cas_last, ack_total, cbr_total, cbr_bad;
    logic p1_cas, p2_cas, p1_ras, uwe_col, lwe_col;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0; ras_run <= 0; cas_run <= 0; ras_last <= 0; cas_last <= 0;
            ack_total <= 0; cbr_total <= 0; cbr_bad <= 0;
            p1_cas <= 1'b1; p2_cas <= 1'b1; p1_ras <= 1'b1; uwe_col <= 1'b1; lwe_col <= 1'b1;
        end else begin
            cyc     <= cyc + 1;
            ras_run <= !ras_n ? ras_run + 1 : 0;
            cas_run <= !cas_n ? cas_run + 1 : 0;
            if (ras_n && ras_run > 0) ras_last <= ras_run;
            if (cas_n && cas_run > 0) cas_last <= cas_run;
            if (!ras_n && !cas_n) begin
                uwe_col <= uwe_n;
                lwe_col <= lwe_n;
            end
            if (ack) ack_total <= ack_total + 1;
            if (!ras_n && p1_ras && !cas_n) begin
                cbr_total <= cbr_total + 1;
                if ({p2_cas, p1_cas} != 2'b10) cbr_bad <= cbr_bad + 1;
            end
            p1_cas <= cas_n;
            p2_cas <= p1_cas;
            p1_ras <= ras_n;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level reference: word memory plus refresh/access scheduling.
    logic [15:0] ref_mem [logic [17:0]];
    int m_free, m_wrap, m_refs, n_acc;

    function automatic int next_wrap(input int d);
        return ((d + REF_INT - 1) / REF_INT) * REF_INT;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_free = 0; m_wrap = REF_INT; m_refs = 0; n_acc = 0;
    endtask

    // Refreshes whose decision edge comes before edge n.
    task automatic model_idle(input int n);
        int d;
        forever begin
            d = max2(m_free, m_wrap + 1);
            if (d >= n) break;
            m_refs++;
            m_free = d + 1 + T_RAS + T_RP;
            m_wrap = next_wrap(d);
        end
    endtask

    // Edge at which a request first visible at edge n is accepted.
    task automatic model_accept(input int n, output int a);
        int d, t;
        model_idle(n);
        forever begin
            d = max2(m_free, m_wrap + 1);
            t = max2(n, m_free);
            if (d <= t) begin
                m_refs++;
                m_free = d + 1 + T_RAS + T_RP;
                m_wrap = next_wrap(d);
            end else begin
                a = t;
                m_free = t + 1 + T_RCD + COL_LEN + T_RP;
                break;
            end
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    endfunction

    // Called 1ns after an edge; returns with the bench 1ns after the ack edge.
    task automatic do_access(input logic w, input logic [1:0] b, input logic [17:0] a,
                             input logic [15:0] d, input logic keep,
                             output int n, output int ack_cyc);
        int acc;
        logic [15:0] cur;
        we = w; be = b; addr = a; wdata = d; req = 1'b1;
        n = cyc + 1;
        model_accept(n, acc);
        ack_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        check_eq("ack_seen", ack, 1'b1);
        if (ack) begin
            check_eq("ack_cycle", ack_cyc, acc + T_RCD + COL_LEN + 1);
            if (!w) check_eq("rdata", rdata, ref_read(a));
        end
        if (w) begin
            cur = ref_read(a);
            if (b[1]) cur[15:8] = d[15:8];
            if (b[0]) cur[7:0]  = d[7:0];
            ref_mem[a] = cur;
        end
        n_acc++;
        if (!keep) req = 1'b0;
    endtask

    logic [17:0] pool [8];

    initial begin
        int n, ac;
        logic [17:0] a;
        for (int i = 0; i < 262144; i++) dmem[i] = 16'h0;
        pool[0] = 18'h000FF; pool[1] = 18'h00100; pool[2] = 18'h3FFFF; pool[3] = 18'h00000;
        pool[4] = 18'h2A5C3; pool[5] = 18'h155AA; pool[6] = 18'h3FF00; pool[7] = 18'h000FE;
        model_reset();

        #2;
        check_eq("rst_pins", {ras_n, cas_n, uwe_n, lwe_n, oe_n, dq_oe, ack, busy, ref_overrun},
                 9'b111110000);
        check_eq("rst_bus", {ma, dq_out, rdata}, 42'h0);

        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;

        // Request and refresh meet in the same idle cycle.
        while (cyc < REF_INT) begin @(posedge clk); #1; end
        do_access(1'b1, 2'b11, 18'h000FF, 16'h5555, 1'b0, n, ac);
        check_eq("ref_collide_lat", ac - n, 1 + T_RAS + T_RP + 6);
        repeat (3) begin @(posedge clk); #1; end
        check_eq("ras_low_len", ras_last, 5);
        check_eq("cas_low_len", cas_last, 3);
        do_access(1'b0, 2'b11, 18'h000FF, 16'h0, 1'b0, n, ac);
        check_eq("read_lat", ac - n, 6);
        check_eq("read_5555", rdata, 16'h5555);

        do_access(1'b1, 2'b11, 18'h00100, 16'h6666, 1'b0, n, ac);
        do_access(1'b1, 2'b10, 18'h00100, 16'hAB00, 1'b0, n, ac);
        check_eq("upper_lanes", {uwe_col, lwe_col}, 2'b01);
        do_access(1'b1, 2'b00, 18'h00100, 16'hFFFF, 1'b0, n, ac);
        check_eq("no_lane_lanes", {uwe_col, lwe_col}, 2'b11);
        do_access(1'b0, 2'b00, 18'h00100, 16'h0, 1'b0, n, ac);
        check_eq("byte_merge", rdata, 16'hAB66);

        // Continuous request across refresh wraps.
        for (int i = 0; i < 12; i++) begin
            a = pool[$urandom_range(0, 7)];
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                      16'($urandom), (i != 11), n, ac);
        end
        repeat (4) begin @(posedge clk); #1; end
        check_eq("ack_count_a", ack_total, n_acc);

        // Reset during ACT of a write abandons it.
        do_access(1'b1, 2'b11, 18'h2A5C3, 16'h1234, 1'b0, n, ac);
        repeat (4) begin @(posedge clk); #1; end
        we = 1'b1; be = 2'b11; addr = 18'h2A5C3; wdata = 16'hDEAD; req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (!ras_n) break;
            @(posedge clk); #1;
        end
        check_eq("act_reached", ras_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid_pins", {ras_n, cas_n, uwe_n, lwe_n, oe_n, dq_oe, ack, busy}, 8'b11111000);
        check_eq("rst_mid_ma", ma, 10'h0);
        req = 1'b0;
        @(posedge clk); #3 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_access(1'b0, 2'b00, 18'h2A5C3, 16'h0, 1'b0, n, ac);
        check_eq("rst_keeps_old", rdata, 16'h1234);

        // Random isolated accesses with idle gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
            a = pool[$urandom_range(0, 7)];
            do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                      16'($urandom), 1'b0, n, ac);
        end
        repeat (20) begin @(posedge clk); #1; end
        model_idle(cyc - 1);
        check_eq("refresh_count", cbr_total, m_refs);
        check_eq("cbr_order", cbr_bad, 0);
        check_eq("ack_count_b", ack_total, n_acc);
        check_eq("no_overrun", ref_overrun, 1'b0);

        // Over-long precharge forces a refresh overrun.
        @(posedge clk); #3 rst2 = 1'b0;
        repeat (100) @(posedge clk);
        #1 check_eq("overrun_early", ov2, 1'b0);
        repeat (2200) @(posedge clk);
        #1 check_eq("overrun_set", ov2, 1'b1);
        repeat (300) @(posedge clk);
        #1 check_eq("overrun_sticky", ov2, 1'b1);
        rst2 = 1'b1;
        #1 check_eq("overrun_rst", ov2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
